// File: rtl/image_ram_loader.sv
// image_ram_loader: packs IN_WIDTH stream chunks into DATA_WIDTH words and writes them to consecutive RAM addresses from 0.
// Define LOADER_READBACK_EN to add a read-back/compare pass after every write (ports ram_dout, verify_err).
module image_ram_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 784,
    parameter int DEPTH      = 2048,
    parameter int IN_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_images,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   img_count,
`ifdef LOADER_READBACK_EN
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  verify_err,
`endif
    output logic                  cfg_err
);
    localparam int CHUNKS = DATA_WIDTH / IN_WIDTH;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE, S_RD, S_CMP} state_t;
    localparam state_t S_ADV = S_CMP;
`else
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
    localparam state_t S_ADV = S_WRITE;
`endif

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_num, r_img_count;
    logic                  r_cfg_err;
    logic                  w_fire, w_last_chunk, w_last_img;
`ifdef LOADER_READBACK_EN
    logic                  r_verify_err;
    assign verify_err = r_verify_err;
`endif

    assign w_fire       = s_valid && r_state == S_FILL;
    assign w_last_chunk = r_cnt == LAST_CHUNK;
    assign w_last_img   = {1'b0, r_addr} == r_num - 1'b1;

    assign s_ready   = r_state == S_FILL;
    assign ram_we    = r_state == S_WRITE;
`ifdef LOADER_READBACK_EN
    assign ram_en    = r_state == S_WRITE || r_state == S_RD;
`else
    assign ram_en    = r_state == S_WRITE;
`endif
    assign ram_addr  = r_addr;
    assign ram_data  = r_shift;
    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_DONE;
    assign img_count = r_img_count;
    assign cfg_err   = r_cfg_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (num_images == '0) ? S_DONE : (num_images > DEPTH_W) ? S_IDLE : S_FILL;
            S_FILL:  if (w_fire && w_last_chunk) w_next = S_WRITE;
`ifdef LOADER_READBACK_EN
            S_WRITE: w_next = S_RD;
            S_RD:    w_next = S_CMP;
            S_CMP:   w_next = w_last_img ? S_DONE : S_FILL;
`else
            S_WRITE: w_next = w_last_img ? S_DONE : S_FILL;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_num       <= '0;
            r_img_count <= '0;
            r_cfg_err   <= 1'b0;
`ifdef LOADER_READBACK_EN
            r_verify_err <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_cfg_err <= num_images > DEPTH_W;
                if (num_images <= DEPTH_W) begin
                    r_addr      <= '0;
                    r_cnt       <= '0;
                    r_img_count <= '0;
                    r_num       <= num_images;
                end
            end
            if (w_fire) begin
                r_shift <= {r_shift[DATA_WIDTH-IN_WIDTH-1:0], s_data};
                r_cnt   <= w_last_chunk ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_WRITE) r_img_count <= r_img_count + 1'b1;
            if (r_state == S_ADV && !w_last_img) r_addr <= r_addr + 1'b1;
`ifdef LOADER_READBACK_EN
            if (r_state == S_CMP && ram_dout != r_shift) r_verify_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_image_ram_loader.sv
// tb_image_ram_loader: expected-write queue model plus directed loads on a default and a 2-chunk instance.
module tb_image_ram_loader;
    localparam int AW = 11, DW = 784, DEPTH = 2048, IW = 8, CH = DW / IW, BIW = 392;
`ifdef LOADER_READBACK_EN
    localparam int PER = CH + 3;
`else
    localparam int PER = CH + 1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          start, s_valid, s_ready, ram_en, ram_we, busy, done, cfg_err;
    logic [AW:0]   num_images, img_count;
    logic [IW-1:0] s_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, dout;
    logic [DW-1:0] mem [DEPTH];

    logic           b_start, b_valid, b_ready, b_en, b_we, b_busy, b_done, b_cfg;
    logic [AW:0]    b_num, b_img;
    logic [BIW-1:0] b_din;
    logic [AW-1:0]  b_addr;
    logic [DW-1:0]  b_dout_w, b_last, b_dout;
`ifdef LOADER_READBACK_EN
    logic verify_err, b_verr;
`endif

    image_ram_loader dut (
        .clk(clk), .rst(rst), .start(start), .num_images(num_images),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .done(done), .img_count(img_count),
`ifdef LOADER_READBACK_EN
        .ram_dout(dout), .verify_err(verify_err),
`endif
        .cfg_err(cfg_err)
    );

    image_ram_loader #(.IN_WIDTH(BIW)) big (
        .clk(clk), .rst(rst), .start(b_start), .num_images(b_num),
        .s_valid(b_valid), .s_data(b_din), .s_ready(b_ready),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_data(b_dout_w),
        .busy(b_busy), .done(b_done), .img_count(b_img),
`ifdef LOADER_READBACK_EN
        .ram_dout(b_dout), .verify_err(b_verr),
`endif
        .cfg_err(b_cfg)
    );

    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t e_cur;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, wr_cnt = 0;
    int b_wr_cnt = 0, b_done_cnt = 0, b_last_addr = -1;

    // RAM model with a stuck-flipped bit 0 at address 5 and registered read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_data ^ DW'(ram_addr == 5);
            else dout <= mem[ram_addr];
        end
        if (b_en && b_we) b_last <= b_dout_w;
        if (b_en && !b_we) b_dout <= b_last;
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkw(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        check("s_ready_only_in_fill", 64'(s_ready && (!busy || ram_en || done)), 64'd0);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ram_en && ram_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else begin
                e_cur = exp_q.pop_front();
                check("write_addr", 64'(ram_addr), 64'(e_cur.a));
                checkw("write_data", ram_data, e_cur.d);
            end
        end
        if (b_done) b_done_cnt++;
        if (b_en && b_we) begin
            check("big_addr_seq", 64'(b_addr), 64'(b_wr_cnt));
            b_wr_cnt++;
            b_last_addr = int'(b_addr);
        end
    end

    function automatic logic [DW-1:0] exp_word(int img);
        logic [DW-1:0] w = '0;
        for (int j = 0; j < CH; j++) w[DW-1-IW*j -: IW] = 8'((img * CH + j) % 256);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic queue_load(int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{AW'(i), exp_word(i)});
    endtask

    task automatic do_start(int n, output int s);
        num_images = (AW + 1)'(n);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic push(int total, bit rnd);
        int k = 0, guard = 0;
        bit hs;
        while (k < total && guard < 20000) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data = 8'(k % 256);
            hs = s_valid && s_ready;
            tick();
            if (hs) k++;
            guard++;
        end
        s_valid = 1'b0;
        if (k < total) check("stream_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done(int prev, int limit);
        int i = 0;
        while (done_cnt == prev && i < limit) begin
            tick();
            i++;
        end
        check("done_seen", 64'(done_cnt > prev), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, d0, w0, i;
        logic [DW-1:0] m0, m1;
        start = 0; num_images = 3; s_valid = 0; s_data = 0;
        b_start = 0; b_num = 0; b_valid = 0; b_din = {49{8'hA5}};
        repeat (3) tick();
        check("rst_s_ready", 64'(s_ready), 0);
        check("rst_ram_en", 64'(ram_en), 0);
        check("rst_ram_we", 64'(ram_we), 0);
        check("rst_ram_addr", 64'(ram_addr), 0);
        checkw("rst_ram_data", ram_data, '0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_img_count", 64'(img_count), 0);
        check("rst_cfg_err", 64'(cfg_err), 0);
`ifdef LOADER_READBACK_EN
        check("rst_verify_err", 64'(verify_err), 0);
`endif
        rst = 0;
        tick();

        do_start(3, s);
        push(50, 0);
        check("mid_fill_busy", 64'(busy), 1);
        w0 = wr_cnt;
        rst = 1;
        #1;
        check("async_rst_busy", 64'(busy), 0);
        tick();
        rst = 0;
        repeat (2) tick();
        check("rst_no_write", 64'(wr_cnt), 64'(w0));
        check("rst_idle_busy", 64'(busy), 0);

        queue_load(2);
        d0 = done_cnt;
        do_start(2, s);
        push(2 * CH, 0);
        wait_done(d0, 400);
        check("done_cycle", 64'(done_cyc - s), 64'(2 * PER + 1));
        check("img_count_2", 64'(img_count), 2);
        check("queue_drained", 64'(exp_q.size()), 0);
        tick();
        check("done_one_cycle", 64'(done), 0);
        check("idle_after_done", 64'(busy), 0);
        m0 = mem[0];
        m1 = mem[1];
        check("w0_msb", 64'(m0[783:776]), 64'h00);
        check("w0_lsb", 64'(m0[7:0]), 64'h61);
        check("w1_msb", 64'(m1[783:776]), 64'h62);
        check("w1_lsb", 64'(m1[7:0]), 64'hC3);
`ifdef LOADER_READBACK_EN
        check("no_verify_err", 64'(verify_err), 0);
`endif

        queue_load(2);
        d0 = done_cnt;
        do_start(2, s);
        push(2 * CH, 1);
        wait_done(d0, 5000);
        checkw("random_w0", mem[0], m0);
        checkw("random_w1", mem[1], m1);
        check("random_img_count", 64'(img_count), 2);
        check("random_queue_drained", 64'(exp_q.size()), 0);

        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(0, s);
        wait_done(d0, 10);
        check("zero_done_cycle", 64'(done_cyc - s), 1);
        check("zero_no_write", 64'(wr_cnt), 64'(w0));
        check("zero_img_count", 64'(img_count), 0);

        d0 = done_cnt;
        do_start(DEPTH + 1, s);
        repeat (4) tick();
        check("cfg_err_set", 64'(cfg_err), 1);
        check("cfg_stay_idle", 64'(busy), 0);
        check("cfg_no_done", 64'(done_cnt), 64'(d0));
        check("cfg_no_write", 64'(wr_cnt), 64'(w0));
        do_start(0, s);
        wait_done(d0, 10);
        check("cfg_err_cleared", 64'(cfg_err), 0);

        b_num = (AW + 1)'(DEPTH);
        b_start = 1;
        tick();
        b_start = 0;
        b_valid = 1;
        repeat (20) tick();
        b_num = 5;
        b_start = 1;
        tick();
        b_start = 0;
        i = 0;
        while (b_done_cnt == 0 && i < 20000) begin
            tick();
            i++;
        end
        b_valid = 0;
        check("big_done_seen", 64'(b_done_cnt), 1);
        check("big_writes", 64'(b_wr_cnt), 64'(DEPTH));
        check("big_last_addr", 64'(b_last_addr), 64'(DEPTH - 1));
        check("big_img_count", 64'(b_img), 64'(DEPTH));
        check("big_cfg_err", 64'(b_cfg), 0);
`ifdef LOADER_READBACK_EN
        check("big_verify_err", 64'(b_verr), 0);
        queue_load(7);
        d0 = done_cnt;
        do_start(7, s);
        push(7 * CH, 0);
        wait_done(d0, 1500);
        check("rb_verify_err", 64'(verify_err), 1);
        check("rb_img_count", 64'(img_count), 7);
        repeat (3) tick();
        check("rb_verify_sticky", 64'(verify_err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
